// File: rtl/mpt_pkg.sv
// Shared constants and types for the MPT walker / PLB cache port arbitration.
package mpt_pkg;

  // Number of requesters sharing the PLB cache memory port.
  localparam int PLB_ARB_NUM_PORTS       = 2;
  // Depth of the in-flight response-ID FIFO (power of two).
  localparam int PLB_ARB_MAX_OUTSTANDING = 4;

  // Requester indices on the shared PLB cache port.
  typedef enum logic [0:0] {
    PLB_ARB_LOOKUP = 1'b0,
    PLB_ARB_REFILL = 1'b1
  } plb_arb_port_e;

  // Increment an index and wrap it back to zero at n.
  function automatic int unsigned plb_arb_wrap_inc(input int unsigned idx,
                                                   input int unsigned n);
    int unsigned v_next;
    v_next = idx + 32'd1;
    if (v_next >= n) begin
      v_next = 32'd0;
    end else begin
      v_next = v_next;
    end
    return v_next;
  endfunction

endpackage

// File: rtl/plb_arb_id_fifo.sv
// In-flight requester-ID FIFO: one entry per granted, not yet answered transaction.
module plb_arb_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == {CW{1'b0}});
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // Protect against overflow/underflow so the pointers never desynchronise.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i  & ~empty_o;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/plb_port_arbiter.sv
// Round-robin arbiter with request lock sharing the PLB cache memory port,
// routing in-order responses back to the requester that issued each transaction.
module plb_port_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_PORTS       = PLB_ARB_NUM_PORTS,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = PLB_ARB_MAX_OUTSTANDING
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_PORTS-1:0]                   s_mem_req,
  output logic [NUM_PORTS-1:0]                   s_mem_gnt,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic [NUM_PORTS-1:0]                   s_mem_we,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   s_mem_wdata,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] s_mem_be,
  output logic [NUM_PORTS-1:0]                   s_mem_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   s_mem_rdata,
  output logic                                   m_mem_req,
  output logic [ADDR_WIDTH-1:0]                  m_mem_addr,
  output logic                                   m_mem_we,
  output logic [DATA_WIDTH-1:0]                  m_mem_wdata,
  output logic [DATA_WIDTH/8-1:0]                m_mem_be,
  input  logic                                   m_mem_gnt,
  input  logic                                   m_mem_valid,
  input  logic [DATA_WIDTH-1:0]                  m_mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
  output logic                                   err_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_lock_vld;
  logic             r_err;

  logic [IDX_W-1:0] w_scan_idx;
  logic             w_scan_vld;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;
  logic             w_grant;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic [IDX_W-1:0] w_rr_nxt;
  logic             w_lock_vld_nxt;
  logic [IDX_W-1:0] w_lock_idx_nxt;

  // Round-robin scan: first requester at or after the rr pointer, wrapping at NUM_PORTS.
  // Offsets are visited from farthest to nearest so the nearest request wins.
  always_comb begin
    logic [IDX_W:0] v_sum;
    w_scan_vld = 1'b0;
    w_scan_idx = {IDX_W{1'b0}};
    v_sum      = {(IDX_W+1){1'b0}};
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (v_sum >= (IDX_W+1)'(NUM_PORTS)) begin
        v_sum = v_sum - (IDX_W+1)'(NUM_PORTS);
      end else begin
        v_sum = v_sum;
      end
      if (s_mem_req[v_sum[IDX_W-1:0]]) begin
        w_scan_vld = 1'b1;
        w_scan_idx = v_sum[IDX_W-1:0];
      end else begin
        w_scan_vld = w_scan_vld;
      end
    end
  end

  // Winner: a locked requester keeps the port; if it dropped its request, nobody wins.
  always_comb begin
    w_win_idx = w_scan_idx;
    w_win_vld = w_scan_vld;
    if (r_lock_vld) begin
      w_win_idx = r_lock_idx;
      w_win_vld = s_mem_req[r_lock_idx];
    end else begin
      w_win_idx = w_scan_idx;
      w_win_vld = w_scan_vld;
    end
  end

  assign w_grant = m_mem_req & m_mem_gnt;
  assign w_pop   = m_mem_valid & ~w_empty;

  // Cache-side request: muxed from the winner, held back while the ID FIFO is full.
  always_comb begin
    m_mem_req   = w_win_vld & ~w_full;
    m_mem_addr  = {ADDR_WIDTH{1'b0}};
    m_mem_we    = 1'b0;
    m_mem_wdata = {DATA_WIDTH{1'b0}};
    m_mem_be    = {BE_W{1'b0}};
    if (m_mem_req) begin
      m_mem_addr  = s_mem_addr[w_win_idx];
      m_mem_we    = s_mem_we[w_win_idx];
      m_mem_wdata = s_mem_wdata[w_win_idx];
      m_mem_be    = s_mem_be[w_win_idx];
    end else begin
      m_mem_addr  = {ADDR_WIDTH{1'b0}};
    end
  end

  // Requester grants: pass the cache grant straight through to the winner only.
  always_comb begin
    s_mem_gnt = {NUM_PORTS{1'b0}};
    if (w_grant) begin
      s_mem_gnt[w_win_idx] = 1'b1;
    end else begin
      s_mem_gnt = {NUM_PORTS{1'b0}};
    end
  end

  // Response routing: the oldest in-flight ID receives this cycle's response.
  always_comb begin
    s_mem_valid = {NUM_PORTS{1'b0}};
    s_mem_rdata = {(NUM_PORTS*DATA_WIDTH){1'b0}};
    if (w_pop) begin
      s_mem_valid[w_head] = 1'b1;
      s_mem_rdata[w_head] = m_mem_rdata;
    end else begin
      s_mem_valid = {NUM_PORTS{1'b0}};
    end
  end

  // Next rr pointer and lock state.
  always_comb begin
    w_rr_nxt       = r_rr_ptr;
    w_lock_vld_nxt = r_lock_vld;
    w_lock_idx_nxt = r_lock_idx;
    if (w_grant) begin
      w_rr_nxt       = IDX_W'(plb_arb_wrap_inc(32'(w_win_idx), NUM_PORTS));
      w_lock_vld_nxt = 1'b0;
    end else if (r_lock_vld && !s_mem_req[r_lock_idx]) begin
      // Locked requester withdrew before being granted: release the port.
      w_lock_vld_nxt = 1'b0;
    end else if (m_mem_req && !m_mem_gnt) begin
      w_lock_vld_nxt = 1'b1;
      w_lock_idx_nxt = w_win_idx;
    end else begin
      w_lock_vld_nxt = r_lock_vld;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr   <= {IDX_W{1'b0}};
      r_lock_vld <= 1'b0;
      r_lock_idx <= {IDX_W{1'b0}};
    end else begin
      r_rr_ptr   <= w_rr_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // Sticky error: a response arrived while nothing was in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (m_mem_valid && w_empty) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_o         = r_err;
  assign outstanding_o = w_count;

  plb_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_grant),
    .data_i  (w_win_idx),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

endmodule

// File: tb/tb_plb_port_arbiter.sv
// Directed self-checking bench for plb_port_arbiter (2 ports, 4 outstanding).
module tb_plb_port_arbiter;

  logic             clk_i;
  logic             rst_ni;
  logic [1:0]       req;
  logic [1:0]       gnt_o;
  logic [1:0][31:0] addr;
  logic [1:0]       we;
  logic [1:0][7:0]  wdata;
  logic [1:0][0:0]  be;
  logic [1:0]       valid_o;
  logic [1:0][7:0]  rdata_o;
  logic             m_req;
  logic [31:0]      m_addr;
  logic             m_we;
  logic [7:0]       m_wdata;
  logic [0:0]       m_be;
  logic             m_gnt;
  logic             m_valid;
  logic [7:0]       m_rdata;
  logic [2:0]       outstanding;
  logic             err;

  int n_cmp;
  int n_mis;

  plb_port_arbiter #(
    .NUM_PORTS       (2),
    .DATA_WIDTH      (8),
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_mem_req     (req),
    .s_mem_gnt     (gnt_o),
    .s_mem_addr    (addr),
    .s_mem_we      (we),
    .s_mem_wdata   (wdata),
    .s_mem_be      (be),
    .s_mem_valid   (valid_o),
    .s_mem_rdata   (rdata_o),
    .m_mem_req     (m_req),
    .m_mem_addr    (m_addr),
    .m_mem_we      (m_we),
    .m_mem_wdata   (m_wdata),
    .m_mem_be      (m_be),
    .m_mem_gnt     (m_gnt),
    .m_mem_valid   (m_valid),
    .m_mem_rdata   (m_rdata),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Move to 1 time unit after the next rising edge (inputs change here).
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Apply and release reset, leaving default stimulus on all inputs.
  task automatic do_reset();
    req     = 2'b00;
    addr[0] = 32'h0000_0100;
    addr[1] = 32'h0000_0200;
    we      = 2'b10;
    wdata[0] = 8'h11;
    wdata[1] = 8'h5A;
    be[0]   = 1'b1;
    be[1]   = 1'b1;
    m_gnt   = 1'b0;
    m_valid = 1'b0;
    m_rdata = 8'h00;
    rst_ni  = 1'b0;
    #3;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b00; m_gnt = 1'b0; m_valid = 1'b0; m_rdata = 8'h00;
    addr[0] = 32'h0; addr[1] = 32'h0; we = 2'b00; wdata[0] = 8'h0; wdata[1] = 8'h0;
    be[0] = 1'b0; be[1] = 1'b0;
    rst_ni = 1'b0;
    #2;
    n_cmp++; if (gnt_o !== 2'b00) begin n_mis++; $display("FAIL reset_gnt got %b exp 00", gnt_o); end
    n_cmp++; if (valid_o !== 2'b00) begin n_mis++; $display("FAIL reset_valid got %b exp 00", valid_o); end
    n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL reset_m_req got %b exp 0", m_req); end
    n_cmp++; if (m_addr !== 32'h0) begin n_mis++; $display("FAIL reset_m_addr got %h exp 0", m_addr); end
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_single_read();
    do_reset();
    addr[0] = 32'h0000_0010;
    req = 2'b01; m_gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 2'b01) begin n_mis++; $display("FAIL single_gnt got %b exp 01", gnt_o); end
    n_cmp++; if (m_addr !== 32'h10) begin n_mis++; $display("FAIL single_addr got %h exp 10", m_addr); end
    n_cmp++; if (m_we !== 1'b0) begin n_mis++; $display("FAIL single_we got %b exp 0", m_we); end
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL single_cnt0 got %0d exp 0", outstanding); end
    step();
    req = 2'b00; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd1) begin n_mis++; $display("FAIL single_cnt1 got %0d exp 1", outstanding); end
    n_cmp++; if (valid_o !== 2'b00) begin n_mis++; $display("FAIL single_valid1 got %b exp 00", valid_o); end
    step();
    m_valid = 1'b1; m_rdata = 8'h01;
    @(negedge clk_i);
    n_cmp++; if (valid_o !== 2'b01) begin n_mis++; $display("FAIL single_valid2 got %b exp 01", valid_o); end
    n_cmp++; if (rdata_o[0] !== 8'h01) begin n_mis++; $display("FAIL single_rdata got %h exp 01", rdata_o[0]); end
    n_cmp++; if (rdata_o[1] !== 8'h00) begin n_mis++; $display("FAIL single_rdata_other got %h exp 00", rdata_o[1]); end
    n_cmp++; if (outstanding !== 3'd1) begin n_mis++; $display("FAIL single_cnt2 got %0d exp 1", outstanding); end
    step();
    m_valid = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL single_cnt3 got %0d exp 0", outstanding); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt [4];
    logic [31:0] exp_addr [4];
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
    do_reset();
    req = 2'b11; m_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      n_cmp++; if (gnt_o !== exp_gnt[c]) begin n_mis++; $display("FAIL rr_gnt[%0d] got %b exp %b", c, gnt_o, exp_gnt[c]); end
      n_cmp++; if (m_addr !== exp_addr[c]) begin n_mis++; $display("FAIL rr_addr[%0d] got %h exp %h", c, m_addr, exp_addr[c]); end
      n_cmp++; if (m_we !== exp_gnt[c][1]) begin n_mis++; $display("FAIL rr_we[%0d] got %b exp %b", c, m_we, exp_gnt[c][1]); end
      step();
    end
    req = 2'b00; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd4) begin n_mis++; $display("FAIL rr_cnt got %0d exp 4", outstanding); end
    step();
    for (int c = 0; c < 4; c++) begin
      m_valid = 1'b1; m_rdata = 8'hA0 + 8'(c);
      @(negedge clk_i);
      n_cmp++; if (valid_o !== exp_gnt[c]) begin n_mis++; $display("FAIL rr_valid[%0d] got %b exp %b", c, valid_o, exp_gnt[c]); end
      n_cmp++; if (rdata_o[c%2] !== (8'hA0 + 8'(c))) begin n_mis++; $display("FAIL rr_rdata[%0d] got %h exp %h", c, rdata_o[c%2], 8'hA0 + 8'(c)); end
      step();
    end
    m_valid = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL rr_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_lock();
    do_reset();
    addr[1] = 32'h0000_0300;
    req = 2'b10; m_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_cmp++; if (m_addr !== 32'h300) begin n_mis++; $display("FAIL lock_addr[%0d] got %h exp 300", c, m_addr); end
      n_cmp++; if (gnt_o !== 2'b00) begin n_mis++; $display("FAIL lock_gnt[%0d] got %b exp 00", c, gnt_o); end
      step();
      req = 2'b11;
    end
    m_gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 2'b10) begin n_mis++; $display("FAIL lock_gnt3 got %b exp 10", gnt_o); end
    n_cmp++; if (m_addr !== 32'h300) begin n_mis++; $display("FAIL lock_addr3 got %h exp 300", m_addr); end
    step();
    req = 2'b01;
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 2'b01) begin n_mis++; $display("FAIL lock_gnt4 got %b exp 01", gnt_o); end
    n_cmp++; if (m_addr !== 32'h100) begin n_mis++; $display("FAIL lock_addr4 got %h exp 100", m_addr); end
    step();
    req = 2'b00; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd2) begin n_mis++; $display("FAIL lock_cnt got %0d exp 2", outstanding); end
  endtask

  task automatic test_lock_drop();
    do_reset();
    req = 2'b10; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL drop_req0 got %b exp 1", m_req); end
    step();
    req = 2'b01; m_gnt = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL drop_req1 got %b exp 0", m_req); end
    n_cmp++; if (gnt_o !== 2'b00) begin n_mis++; $display("FAIL drop_gnt1 got %b exp 00", gnt_o); end
    step();
    @(negedge clk_i);
    n_cmp++; if (gnt_o !== 2'b01) begin n_mis++; $display("FAIL drop_gnt2 got %b exp 01", gnt_o); end
    step();
    req = 2'b00; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd1) begin n_mis++; $display("FAIL drop_cnt got %0d exp 1", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    req = 2'b11; m_gnt = 1'b1;
    repeat (4) step();
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd4) begin n_mis++; $display("FAIL full_cnt got %0d exp 4", outstanding); end
    n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL full_req got %b exp 0", m_req); end
    n_cmp++; if (gnt_o !== 2'b00) begin n_mis++; $display("FAIL full_gnt got %b exp 00", gnt_o); end
    step();
    m_valid = 1'b1; m_rdata = 8'h77;
    @(negedge clk_i);
    n_cmp++; if (valid_o !== 2'b01) begin n_mis++; $display("FAIL full_valid got %b exp 01", valid_o); end
    n_cmp++; if (rdata_o[0] !== 8'h77) begin n_mis++; $display("FAIL full_rdata got %h exp 77", rdata_o[0]); end
    n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL full_req_pop got %b exp 0", m_req); end
    step();
    m_valid = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd3) begin n_mis++; $display("FAIL full_cnt3 got %0d exp 3", outstanding); end
    n_cmp++; if (m_req !== 1'b1) begin n_mis++; $display("FAIL full_rereq got %b exp 1", m_req); end
    n_cmp++; if (gnt_o !== 2'b01) begin n_mis++; $display("FAIL full_regnt got %b exp 01", gnt_o); end
    step();
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd4) begin n_mis++; $display("FAIL full_cnt4 got %0d exp 4", outstanding); end
    n_cmp++; if (m_req !== 1'b0) begin n_mis++; $display("FAIL full_req2 got %b exp 0", m_req); end
    req = 2'b00; m_gnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 2'b01; m_gnt = 1'b1;
    step();
    req = 2'b10;
    step();
    req = 2'b01; m_valid = 1'b1; m_rdata = 8'h3C;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd2) begin n_mis++; $display("FAIL b2b_cnt_a got %0d exp 2", outstanding); end
    n_cmp++; if (gnt_o !== 2'b01) begin n_mis++; $display("FAIL b2b_gnt got %b exp 01", gnt_o); end
    n_cmp++; if (valid_o !== 2'b01) begin n_mis++; $display("FAIL b2b_valid0 got %b exp 01", valid_o); end
    n_cmp++; if (rdata_o[0] !== 8'h3C) begin n_mis++; $display("FAIL b2b_rdata0 got %h exp 3c", rdata_o[0]); end
    n_cmp++; if (rdata_o[1] !== 8'h00) begin n_mis++; $display("FAIL b2b_rdata_other got %h exp 00", rdata_o[1]); end
    step();
    req = 2'b00; m_gnt = 1'b0; m_rdata = 8'h4D;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd2) begin n_mis++; $display("FAIL b2b_cnt_b got %0d exp 2", outstanding); end
    n_cmp++; if (valid_o !== 2'b10) begin n_mis++; $display("FAIL b2b_valid1 got %b exp 10", valid_o); end
    n_cmp++; if (rdata_o[1] !== 8'h4D) begin n_mis++; $display("FAIL b2b_rdata1 got %h exp 4d", rdata_o[1]); end
    step();
    m_valid = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (outstanding !== 3'd1) begin n_mis++; $display("FAIL b2b_cnt_c got %0d exp 1", outstanding); end
  endtask

  task automatic test_err_and_async_reset();
    do_reset();
    m_valid = 1'b1; m_rdata = 8'hEE;
    @(negedge clk_i);
    n_cmp++; if (valid_o !== 2'b00) begin n_mis++; $display("FAIL err_valid got %b exp 00", valid_o); end
    n_cmp++; if (rdata_o !== 16'h0000) begin n_mis++; $display("FAIL err_rdata got %h exp 0000", rdata_o); end
    step();
    m_valid = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_set got %b exp 1", err); end
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL err_cnt got %0d exp 0", outstanding); end
    step();
    req = 2'b01; m_gnt = 1'b1;
    step();
    req = 2'b00; m_gnt = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_sticky got %b exp 1", err); end
    n_cmp++; if (outstanding !== 3'd1) begin n_mis++; $display("FAIL err_cnt1 got %0d exp 1", outstanding); end
    step();
    req = 2'b11;
    #1;
    n_cmp++; if (m_addr !== 32'h200) begin n_mis++; $display("FAIL arst_pre_addr got %h exp 200", m_addr); end
    #1;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL arst_err got %b exp 0", err); end
    n_cmp++; if (outstanding !== 3'd0) begin n_mis++; $display("FAIL arst_cnt got %0d exp 0", outstanding); end
    n_cmp++; if (m_addr !== 32'h100) begin n_mis++; $display("FAIL arst_rr_addr got %h exp 100", m_addr); end
    req = 2'b00;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_full();
    test_back_to_back();
    test_err_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
